branch_predictor: RTL and testbench

- Fetch-side counterpart of the EX-stage branch resolution logic in the pipelined RV32I core.
- Predicts the next PC in IF from a direct-mapped table. Each entry holds a valid bit, a tag, a target and a 2-bit saturating counter.
- Takes the resolved outcome back from EX (the branch-taken select plus the computed target), updates the table and flags mispredictions for pipeline flush and redirect.

---
 rtl/branch_predictor.sv | 136 +++++++++++++
 tb/tb_branch_predictor.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor for the RV32I fetch stage.
// Each entry holds valid, tag, target and a 2-bit saturating counter. Lookup is
// combinational on if_pc; the table is updated from the resolved EX outcome.
// Optional macro BPU_BYPASS_EN: forward the same-cycle update into the lookup.
module branch_predictor #(
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned TAG_W   = PC_W - IDX_BITS - 2;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]    if_tag, ex_tag;
    logic                br, ex_hit;

    logic             upd_en;
    logic             upd_valid;
    logic [TAG_W-1:0] upd_tag;
    logic [PC_W-1:0]  upd_tgt;
    logic [1:0]       upd_ctr;

    logic             look_valid;
    logic [TAG_W-1:0] look_tag;
    logic [PC_W-1:0]  look_tgt;
    logic [1:0]       look_ctr;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[PC_W-1:IDX_BITS+2];
    assign br     = ex_valid & ex_is_branch;
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Next value of the entry addressed by ex_pc; gated off while in reset
    always_comb begin
        upd_en    = 1'b0;
        upd_valid = valid_q[ex_idx];
        upd_tag   = tag_q[ex_idx];
        upd_tgt   = tgt_q[ex_idx];
        upd_ctr   = ctr_q[ex_idx];
        if (rst && ex_valid) begin
            if (ex_is_branch) begin
                upd_en = 1'b1;
                if (!ex_hit) begin
                    // Allocate, replacing whatever occupied this index
                    upd_valid = 1'b1;
                    upd_tag   = ex_tag;
                    upd_tgt   = ex_target;
                    upd_ctr   = ex_taken ? 2'b10 : 2'b01;
                end else if (ex_taken) begin
                    upd_tgt = ex_target;
                    upd_ctr = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                end else begin
                    upd_ctr = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
                end
            end else if (ex_hit) begin
                // Non-branch matched a stale entry: drop it
                upd_en    = 1'b1;
                upd_valid = 1'b0;
            end
        end
    end

    // Table storage with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_en) begin
            valid_q[ex_idx] <= upd_valid;
            tag_q[ex_idx]   <= upd_tag;
            tgt_q[ex_idx]   <= upd_tgt;
            ctr_q[ex_idx]   <= upd_ctr;
        end
    end

    // Zero-latency lookup of the entry addressed by if_pc
    always_comb begin
        look_valid = valid_q[if_idx];
        look_tag   = tag_q[if_idx];
        look_tgt   = tgt_q[if_idx];
        look_ctr   = ctr_q[if_idx];
`ifdef BPU_BYPASS_EN
        if (upd_en && (ex_idx == if_idx)) begin
            look_valid = upd_valid;
            look_tag   = upd_tag;
            look_tgt   = upd_tgt;
            look_ctr   = upd_ctr;
        end
`endif
        pred_hit    = look_valid && (look_tag == if_tag);
        pred_taken  = pred_hit && look_ctr[1];
        pred_target = pred_taken ? look_tgt : if_pc + PC_W'(4);
    end

    // Misprediction detection and redirect target from the EX outcome
    always_comb begin
        mispredict = 1'b0;
        if (rst) begin
            if (br) begin
                mispredict = (ex_taken != ex_pred_taken) ||
                             (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
            end else if (ex_valid && ex_pred_taken) begin
                mispredict = 1'b1;
            end
        end
        redirect_pc = (br && ex_taken) ? ex_target : ex_pc + PC_W'(4);
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic checked against a behavioural table model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: 16 entries, index = (pc/4) mod 16, tag = pc/64
    bit          mv   [16];
    logic [31:0] mtag [16];
    logic [31:0] mtgt [16];
    int          mctr [16];

    branch_predictor #(.IDX_BITS(4), .PC_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = 1;
        end
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                                     output logic [31:0] tgt);
        int i = m_idx(pc);
        hit = mv[i] && (mtag[i] == pc / 64);
        tk  = hit && (mctr[i] >= 2);
        tgt = tk ? mtgt[i] : pc + 32'd4;
    endfunction

    function automatic void m_update(input bit v, input bit b, input logic [31:0] pc,
                                     input bit tk, input logic [31:0] target);
        int  i = m_idx(pc);
        bit  hit = mv[i] && (mtag[i] == pc / 64);
        if (!v) return;
        if (b) begin
            if (!hit) begin
                mv[i] = 1; mtag[i] = pc / 64; mtgt[i] = target; mctr[i] = tk ? 2 : 1;
            end else if (tk) begin
                mctr[i] = (mctr[i] + 1 > 3) ? 3 : mctr[i] + 1;
                mtgt[i] = target;
            end else begin
                mctr[i] = (mctr[i] - 1 < 0) ? 0 : mctr[i] - 1;
            end
        end else if (hit) begin
            mv[i] = 0;
        end
    endfunction

    function automatic void m_resolve(output bit mp, output logic [31:0] rd);
        bit br = ex_valid && ex_is_branch;
        mp = (br && (ex_taken != ex_pred_taken)) ||
             (br && ex_taken && ex_pred_taken && (ex_target != ex_pred_target)) ||
             (ex_valid && !ex_is_branch && ex_pred_taken);
        rd = (br && ex_taken) ? ex_target : ex_pc + 32'd4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input bit v, input bit b, input logic [31:0] pc, input bit tk,
                          input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        ex_valid = v; ex_is_branch = b; ex_pc = pc; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_pc = 32'h100;
        set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        #2;
        vectors++;
        if (mispredict !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mispredict: got %b want 0", mispredict);
        end
        tick(); tick();
        rst = 1'b1;
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #2;
        vectors++;
        if ({pred_hit, pred_taken} !== 2'b00 || pred_target !== 32'h104) begin
            miscompares++;
            $display("FAIL reset_lookup: got hit=%b tk=%b tgt=%h want 0 0 00000104",
                     pred_hit, pred_taken, pred_target);
        end
        if_pc = 32'hFFFF_FFFC;
        #1;
        vectors++;
        if (pred_target !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_wrap: got tgt=%h want 00000000", pred_target);
        end
        tick();
    endtask

    task automatic test_alloc();
        if_pc = 32'h204;
        set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        #2;
        vectors++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
            miscompares++;
            $display("FAIL alloc_resolve: got mp=%b rd=%h want 1 00000080", mispredict,
                     redirect_pc);
        end
        tick();
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        if_pc = 32'h100;
        #2;
        vectors++;
        if ({pred_hit, pred_taken} !== 2'b11 || pred_target !== 32'h80) begin
            miscompares++;
            $display("FAIL alloc_lookup: got hit=%b tk=%b tgt=%h want 1 1 00000080",
                     pred_hit, pred_taken, pred_target);
        end
        tick();
    endtask

    task automatic test_saturate();
        if_pc = 32'h204;
        for (int n = 0; n < 3; n++) begin
            set_ex(1, 1, 32'h100, 1, 32'h80, 1, 32'h80);
            #2;
            vectors++;
            if (mispredict !== 1'b0) begin
                miscompares++;
                $display("FAIL sat_taken_%0d: got mp=%b want 0", n, mispredict);
            end
            tick();
        end
        // 11 -> 10 still predicts taken; 10 -> 01 predicts not-taken
        for (int n = 0; n < 2; n++) begin
            set_ex(1, 1, 32'h101, 0, 32'h80, 1, 32'h80);
            if_pc = 32'h204;
            #2;
            vectors++;
            if (mispredict !== 1'b1 || redirect_pc !== 32'h105) begin
                miscompares++;
                $display("FAIL sat_nt_resolve_%0d: got mp=%b rd=%h want 1 00000105", n,
                         mispredict, redirect_pc);
            end
            tick();
            set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
            if_pc = 32'h102;
            #2;
            vectors++;
            if (pred_hit !== 1'b1 || pred_taken !== (n == 0) ||
                pred_target !== ((n == 0) ? 32'h80 : 32'h106)) begin
                miscompares++;
                $display("FAIL sat_nt_lookup_%0d: got hit=%b tk=%b tgt=%h want 1 %0d %h", n,
                         pred_hit, pred_taken, pred_target, n == 0,
                         (n == 0) ? 32'h80 : 32'h106);
            end
            tick();
        end
    endtask

    task automatic test_alias();
        if_pc = 32'h204;
        set_ex(1, 1, 32'h140, 0, 32'h300, 0, 32'h144);
        #2;
        vectors++;
        if (mispredict !== 1'b0) begin
            miscompares++;
            $display("FAIL alias_resolve: got mp=%b want 0", mispredict);
        end
        tick();
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        if_pc = 32'h100;
        #2;
        vectors++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h104) begin
            miscompares++;
            $display("FAIL alias_old: got hit=%b tgt=%h want 0 00000104", pred_hit,
                     pred_target);
        end
        if_pc = 32'h140;
        #1;
        vectors++;
        if ({pred_hit, pred_taken} !== 2'b10 || pred_target !== 32'h144) begin
            miscompares++;
            $display("FAIL alias_new: got hit=%b tk=%b tgt=%h want 1 0 00000144",
                     pred_hit, pred_taken, pred_target);
        end
        tick();
    endtask

    task automatic test_stale();
        if_pc = 32'h204;
        set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        tick();
        set_ex(1, 0, 32'h100, 0, 32'h0, 1, 32'h80);
        #2;
        vectors++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h104) begin
            miscompares++;
            $display("FAIL stale_resolve: got mp=%b rd=%h want 1 00000104", mispredict,
                     redirect_pc);
        end
        tick();
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        if_pc = 32'h100;
        #2;
        vectors++;
        if (pred_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_invalidate: got hit=%b want 0", pred_hit);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        bit          exp_hit;
        logic [31:0] exp_tgt;
`ifdef BPU_BYPASS_EN
        exp_hit = 1; exp_tgt = 32'h80;
`else
        exp_hit = 0; exp_tgt = 32'h104;
`endif
        if_pc = 32'h100;
        set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        #2;
        vectors++;
        if (pred_hit !== exp_hit || pred_target !== exp_tgt) begin
            miscompares++;
            $display("FAIL same_cycle: got hit=%b tgt=%h want %b %h", pred_hit, pred_target,
                     exp_hit, exp_tgt);
        end
        tick();
    endtask

    task automatic test_async_reset();
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        if_pc = 32'h100;
        #2;
        vectors++;
        if (pred_hit !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre: got hit=%b want 1", pred_hit);
        end
        set_ex(1, 1, 32'h140, 1, 32'h90, 0, 32'h144);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (pred_hit !== 1'b0 || mispredict !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_now: got hit=%b mp=%b want 0 0", pred_hit, mispredict);
        end
        tick();
        if_pc = 32'h140;
        #1;
        vectors++;
        if (pred_hit !== 1'b0 || mispredict !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_hold: got hit=%b mp=%b want 0 0", pred_hit, mispredict);
        end
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        rst = 1'b1;
        m_reset();
        tick();
    endtask

    task automatic test_random();
        bit          hit, tk, mp, ph, ptk;
        logic [31:0] tgt, rd, ptgt, pc_e;
        for (int n = 0; n < 400; n++) begin
            if_pc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 5) << 2) |
                    $urandom_range(0, 3);
            pc_e  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 5) << 2) |
                    $urandom_range(0, 3);
            m_lookup(pc_e, ph, ptk, ptgt);
            if ($urandom_range(0, 1) == 1) begin
                ptk  = $urandom_range(0, 1) == 1;
                ptgt = {$urandom_range(0, 3), 4'h0};
            end
            set_ex($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, pc_e,
                   $urandom_range(0, 1) == 1, {$urandom_range(0, 3), 4'h0}, ptk, ptgt);
            #2;
            m_resolve(mp, rd);
`ifdef BPU_BYPASS_EN
            m_update(ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target);
            m_lookup(if_pc, hit, tk, tgt);
`else
            m_lookup(if_pc, hit, tk, tgt);
            m_update(ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target);
`endif
            vectors++;
            if (pred_hit !== hit || pred_taken !== tk || pred_target !== tgt) begin
                miscompares++;
                $display("FAIL rand_lookup_%0d: pc=%h got %b %b %h want %b %b %h", n, if_pc,
                         pred_hit, pred_taken, pred_target, hit, tk, tgt);
            end
            vectors++;
            if (mispredict !== mp || (mp && redirect_pc !== rd)) begin
                miscompares++;
                $display("FAIL rand_resolve_%0d: got mp=%b rd=%h want %b %h", n, mispredict,
                         redirect_pc, mp, rd);
            end
            tick();
        end
        set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        m_reset();
        test_reset();
        test_alloc();
        test_saturate();
        test_alias();
        test_stale();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
